gray_codec_pipe: RTL

Parametrised, pipelined, bidirectional binary/Gray code converter with valid/ready flow control. Each beat carries its own direction flag, so a single instance serves both pointer encoding (binary→Gray) and pointer decoding (Gray→binary) streams. The Gray→binary XOR prefix chain is split across register stages so wide words close timing. It sits between pointer/counter logic and clock-domain-crossing or status logic, anywhere a combinational converter would otherwise lie on a critical path.

---
 rtl/gray_codec_pipe.sv | 100 ++++++++++
 1 files changed

// File: rtl/gray_codec_pipe.sv
// Pipelined binary<->Gray converter with valid/ready flow control.
// Each beat carries its own direction; the Gray decode chain is split MSB-first across the stages.
module gray_codec_pipe #(
  parameter int DATA_WIDTH = 8,
  parameter int STAGES     = 2
) (
  input  logic                  iClk,
  input  logic                  iRst,
  input  logic                  iValid,
  output logic                  oReady,
  input  logic                  iMode,
  input  logic [DATA_WIDTH-1:0] iData,
  output logic                  oValid,
  input  logic                  iReady,
  output logic                  oMode,
  output logic [DATA_WIDTH-1:0] oData
);

  localparam int SEG = (DATA_WIDTH + STAGES - 1) / STAGES;

  logic [STAGES-1:0]     validQ;
  logic [STAGES-1:0]     modeQ;
  logic [DATA_WIDTH-1:0] dataQ [STAGES];

  logic [STAGES-1:0]     stageReady;
  logic [STAGES-1:0]     prevValid;
  logic [STAGES-1:0]     prevMode;
  logic [DATA_WIDTH-1:0] prevData [STAGES];
  logic [DATA_WIDTH-1:0] nextData [STAGES];

  // Stage k resolves its own segment of the decode chain; bits above are already binary,
  // bits below are still raw Gray. Encoding finishes entirely in the first stage.
  function automatic logic [DATA_WIDTH-1:0] stageXform(input logic [DATA_WIDTH-1:0] w,
                                                       input logic mode, input int k);
    logic [DATA_WIDTH-1:0] r;
    int hi;
    int lo;
    r  = w;
    hi = DATA_WIDTH - 1 - k * SEG;
    lo = DATA_WIDTH - (k + 1) * SEG;
    if (!mode) begin
      if (k == 0) r = w ^ (w >> 1);
    end else begin
      for (int i = DATA_WIDTH - 2; i >= 0; i--) begin
        if (i <= hi && i >= lo) r[i] = r[i+1] ^ r[i];
      end
    end
    return r;
  endfunction

  // A stage may load when it is empty or anything downstream of it can move.
  always_comb begin
    logic acc;
    stageReady = '0;
    acc = iReady;
    for (int k = STAGES - 1; k >= 0; k--) begin
      acc = acc | ~validQ[k];
      stageReady[k] = acc;
    end
  end

  always_comb begin
    prevValid[0] = iValid;
    prevMode[0]  = iMode;
    prevData[0]  = iData;
    for (int k = 1; k < STAGES; k++) begin
      prevValid[k] = validQ[k-1];
      prevMode[k]  = modeQ[k-1];
      prevData[k]  = dataQ[k-1];
    end
    for (int k = 0; k < STAGES; k++) begin
      nextData[k] = stageXform(prevData[k], prevMode[k], k);
    end
  end

  // Payload registers only load with a valid beat so a stalled output never changes.
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      validQ <= '0;
      modeQ  <= '0;
      for (int k = 0; k < STAGES; k++) dataQ[k] <= '0;
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        if (stageReady[k]) begin
          validQ[k] <= prevValid[k];
          if (prevValid[k]) begin
            dataQ[k] <= nextData[k];
            modeQ[k] <= prevMode[k];
          end
        end
      end
    end
  end

  assign oReady = stageReady[0];
  assign oValid = validQ[STAGES-1];
  assign oMode  = modeQ[STAGES-1];
  assign oData  = dataQ[STAGES-1];

endmodule
